// File: rtl/adc_uart_pkg.sv
// Shared FSM state encoding and frame byte constants for the ADC-to-UART framer.
package adc_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND,
        GAP
    } state_t;

    localparam logic [7:0] PFX_A   = 8'h41;
    localparam logic [7:0] PFX_D   = 8'h44;
    localparam logic [7:0] PFX_C   = 8'h43;
    localparam logic [7:0] PFX_EQ  = 8'h3D;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;
    localparam logic [7:0] ASCII_0 = 8'h30;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return ASCII_0 | {4'h0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per cycle, DATA_W
// cycles after start, followed by a single-cycle done pulse.
module bin2bcd_seq #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     din,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              running_q;

    // Bump every BCD digit of 5 or more by 3 ahead of the left shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (r[d*4 +: 4] >= 4'd5) begin
                r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q     <= '0;
            bcd       <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin_q     <= din;
                bcd       <= '0;
                cnt_q     <= CNT_W'(DATA_W);
                running_q <= 1'b1;
            end else if (running_q) begin
                {bcd, bin_q} <= {add3(bcd), bin_q} << 1;
                cnt_q        <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    running_q <= 1'b0;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adc_tx_framer.sv
// Frames each accepted ADC sample as "ADC=dddd\r\n" and streams it one byte
// at a time to a UART transmitter using a valid/busy handshake.
module adc_tx_framer
    import adc_uart_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic              RST_clk,
    input  logic              RST,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic              sample_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              frame_done,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned FRAME_LEN = 6 + DIGITS;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned LAST_IDX  = FRAME_LEN - 1;
    localparam int unsigned BCD_W     = DIGITS * 4;
    localparam int unsigned POS_W     = $clog2(BCD_W);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        tx_data_d;
    logic              tx_valid_d;
    logic              frame_done_d;
    logic              ready_d;
    logic [7:0]        drop_d;
    logic              conv_start_c;
    logic              conv_done;
    logic [BCD_W-1:0]  bcd;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (RST_clk),
        .rst   (RST),
        .start (conv_start_c),
        .din   (sample_data),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Byte at frame position i: prefix, digits MSD first, then CR LF.
    function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] i,
                                           input logic [BCD_W-1:0] b);
        int unsigned      k;
        logic [POS_W-1:0] pos;
        logic [7:0]       r;
        k   = 32'(i);
        pos = POS_W'(((DIGITS + 3) - k) * 4);
        if (k == 0)                r = PFX_A;
        else if (k == 1)           r = PFX_D;
        else if (k == 2)           r = PFX_C;
        else if (k == 3)           r = PFX_EQ;
        else if (k < 4 + DIGITS)   r = ascii_digit(b[pos +: 4]);
        else if (k == 4 + DIGITS)  r = CR;
        else                       r = LF;
        return r;
    endfunction

    always_ff @(posedge RST_clk) begin
        if (RST) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tx_data      <= 8'h00;
            tx_valid     <= 1'b0;
            frame_done   <= 1'b0;
            sample_ready <= 1'b1;
            drop_cnt     <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tx_data      <= tx_data_d;
            tx_valid     <= tx_valid_d;
            frame_done   <= frame_done_d;
            sample_ready <= ready_d;
            drop_cnt     <= drop_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data;
        tx_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        conv_start_c = 1'b0;
        drop_d       = drop_cnt;

        if (sample_valid && !sample_ready && drop_cnt != 8'hFF) begin
            drop_d = drop_cnt + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (sample_valid && sample_ready) begin
                    conv_start_c = 1'b1;
                    state_d      = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d    = SEND;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = byte_at(IDX_W'(0), bcd);
                end
            end
            SEND: begin
                tx_valid_d = 1'b1;
                if (!tx_busy) begin
                    state_d      = GAP;
                    tx_valid_d   = 1'b0;
                    frame_done_d = (idx_q == IDX_W'(LAST_IDX));
                end
            end
            GAP: begin
                // The LF byte is always the last index, so index end marks frame end.
                if (idx_q == IDX_W'(LAST_IDX)) begin
                    state_d = IDLE;
                end else begin
                    state_d    = SEND;
                    idx_d      = idx_q + IDX_W'(1);
                    tx_valid_d = 1'b1;
                    tx_data_d  = byte_at(idx_q + IDX_W'(1), bcd);
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_adc_tx_framer.sv
// Self-checking bench for adc_tx_framer: fixed frame vectors, reset abort,
// drop-counter saturation and randomized frames against a decimal model.
module tb_adc_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic        sample_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;
    int drop_model = 0;
    bit in_frame = 1'b0;

    adc_tx_framer #(
        .DATA_W (12),
        .DIGITS (4)
    ) dut (
        .RST_clk      (clk),
        .RST          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_busy      (tx_busy),
        .frame_done   (frame_done),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] data;
        int          stall;
        bit          hold;
        logic [31:0] digits;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; the drop model counts edges that see a sample offered mid-frame.
    task automatic tick();
        @(posedge clk);
        if (sample_valid && in_frame && drop_model < 255) drop_model++;
        if (rst) drop_model = 0;
        #1;
    endtask

    function automatic logic [31:0] dec_digits(input int v);
        logic [31:0] r;
        r[31:24] = 8'h30 + 8'(v / 1000);
        r[23:16] = 8'h30 + 8'((v / 100) % 10);
        r[15:8]  = 8'h30 + 8'((v / 10) % 10);
        r[7:0]   = 8'h30 + 8'(v % 10);
        return r;
    endfunction

    task automatic do_frame(input logic [11:0] d, input int stall, input bit hold,
                            input logic [31:0] digits, input int abort_after, input string tag);
        logic [79:0] exp;
        logic [7:0]  expb;
        int          cyc;
        int          bad;
        exp = {"ADC=", digits, 8'h0D, 8'h0A};
        cyc = 0;
        while (sample_ready !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        check({tag, " ready"}, 32'(sample_ready), 32'd1);
        sample_data  = d;
        sample_valid = 1'b1;
        tick();
        in_frame = 1'b1;
        if (!hold) sample_valid = 1'b0;
        check({tag, " busy"}, 32'(sample_ready), 32'd0);
        cyc = 0;
        while (tx_valid !== 1'b1 && cyc < 50) begin tick(); cyc++; end
        check({tag, " latency"}, 32'(cyc), 32'd13);
        for (int b = 0; b < 10; b++) begin
            expb = exp[79-8*b -: 8];
            cyc = 0;
            while (tx_valid !== 1'b1 && cyc < 50) begin tick(); cyc++; end
            check($sformatf("%s byte%0d", tag, b), 32'({tx_valid, tx_data}), 32'({1'b1, expb}));
            bad = 0;
            tx_busy = 1'b1;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (tx_valid !== 1'b1 || tx_data !== expb) bad++;
            end
            if (stall > 0) check($sformatf("%s stall%0d", tag, b), 32'(bad), 32'd0);
            tx_busy = 1'b0;
            tick();
            check($sformatf("%s gap%0d", tag, b), 32'({tx_valid, frame_done}),
                  32'({1'b0, (b == 9)}));
            if (b + 1 == abort_after) begin
                rst = 1'b1;
                sample_valid = 1'b0;
                tick();
                rst = 1'b0;
                in_frame = 1'b0;
                check({tag, " rst state"}, 32'({sample_ready, tx_valid, frame_done, tx_data}),
                      32'({1'b1, 1'b0, 1'b0, 8'h00}));
                check({tag, " rst drop"}, 32'(drop_cnt), 32'd0);
                bad = 0;
                for (int s = 0; s < 40; s++) begin
                    tick();
                    if (tx_valid !== 1'b0 || frame_done !== 1'b0) bad++;
                end
                check({tag, " no bytes after rst"}, 32'(bad), 32'd0);
                return;
            end
        end
        tick();
        in_frame = 1'b0;
        sample_valid = 1'b0;
        check({tag, " idle"}, 32'({sample_ready, tx_valid, frame_done}), 32'(3'b100));
        check({tag, " drop"}, 32'(drop_cnt), 32'(drop_model));
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{12'd255,  0,  1'b0, "0255"};
        vecs[1] = '{12'hFFF,  20, 1'b0, "4095"};
        vecs[2] = '{12'd1234, 0,  1'b0, "1234"};
        vecs[3] = '{12'd4000, 0,  1'b0, "4000"};
        vecs[4] = '{12'd0,    30, 1'b1, "0000"};

        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        tx_busy      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset state", 32'({sample_ready, tx_valid, frame_done, tx_data}),
              32'({1'b1, 1'b0, 1'b0, 8'h00}));
        check("reset drop", 32'(drop_cnt), 32'd0);

        for (int i = 0; i < 5; i++) begin
            do_frame(vecs[i].data, vecs[i].stall, vecs[i].hold, vecs[i].digits, 0,
                     $sformatf("vec%0d", i));
            if (i == 3) check("b2b drop zero", 32'(drop_cnt), 32'd0);
        end
        check("drop saturated", 32'(drop_cnt), 32'd255);

        do_frame(12'd777, 0, 1'b1, "0777", 5, "abort");

        for (int i = 0; i < 8; i++) begin
            int v;
            v = int'($urandom_range(0, 4095));
            do_frame(12'(v), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                     dec_digits(v), 0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
